// File: rtl/alarm_set_ctrl_pkg.sv
// Shared definitions for the alarm-set controller.
//   state_e     : controller states
//   FIELD_*     : edit_field codes driven to the display (blink select)
//   HOUR_MAX    : last valid hour value in BCD
//   MINSEC_MAX  : last valid minute/second value in BCD
//   field_of()  : maps a state onto the edit_field code shown while in it
package alarm_set_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_LOAD,
        ST_EDIT_H,
        ST_EDIT_M,
        ST_EDIT_S,
        ST_COMMIT
    } state_e;

    localparam logic [1:0] FIELD_NONE   = 2'd0;
    localparam logic [1:0] FIELD_HOUR   = 2'd1;
    localparam logic [1:0] FIELD_MINUTE = 2'd2;
    localparam logic [1:0] FIELD_SECOND = 2'd3;

    localparam logic [7:0] HOUR_MAX   = 8'h23;
    localparam logic [7:0] MINSEC_MAX = 8'h59;

    function automatic logic [1:0] field_of(input state_e s);
        case (s)
            ST_EDIT_H: return FIELD_HOUR;
            ST_EDIT_M: return FIELD_MINUTE;
            ST_EDIT_S: return FIELD_SECOND;
            default:   return FIELD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/alarm_set_ctrl_bcd2_updown.sv
// Combinational two-digit BCD step by one, wrapping between 00 and MAX.
//   val_i : current BCD value
//   up_i  : 1 = increment, 0 = decrement
//   res_o : stepped value, always valid BCD in 00..MAX
// Out-of-range inputs (above MAX) are pulled back into range rather than
// stepped, so a corrupt readback can never propagate an illegal code.
module bcd2_updown #(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic [7:0] val_i,
    input  logic       up_i,
    output logic [7:0] res_o
);

    logic [3:0] tens;
    logic [3:0] ones;

    assign tens = val_i[7:4];
    assign ones = val_i[3:0];

    always_comb begin
        res_o = val_i;
        if (up_i) begin
            if (val_i >= MAX)
                res_o = 8'h00;
            else if (ones >= 4'd9)
                res_o = {tens + 4'd1, 4'd0};
            else
                res_o = {tens, ones + 4'd1};
        end else begin
            if (val_i == 8'h00 || val_i > MAX)
                res_o = MAX;
            else if (ones == 4'd0)
                res_o = {tens - 4'd1, 4'd9};
            else
                res_o = {tens, ones - 4'd1};
        end
    end

endmodule

// File: rtl/alarm_set_ctrl.sv
// Button-driven alarm configuration sequencer.
// Picks an alarm slot, waits for its readback to settle, preloads HH:MM:SS,
// lets the user edit each field in BCD and then fires a one-cycle set strobe
// with the edited time and the date captured at load.
//   clk, rst_n            : clock, asynchronous active-low reset
//   tick_1hz              : one-cycle pulse per second (edit timeout base)
//   btn_mode/next/inc/dec : debounced one-cycle button pulses
//   cur_*_bcd             : current date from the timekeeper
//   rb_*_bcd              : alarm readback for the selected slot
//   selected_alarm        : slot index to the alarm block (kept after a session)
//   set                   : one-cycle commit strobe
//   alarm_*_bcd_in        : values presented with set
//   editing, edit_field   : session status for the display
import alarm_set_ctrl_pkg::*;

module alarm_set_ctrl #(
    parameter int NUM_ALARMS   = 3,
    parameter int READBACK_LAT = 4,
    parameter int TIMEOUT_S    = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_1hz,
    input  logic        btn_mode,
    input  logic        btn_next,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic [15:0] cur_year_bcd,
    input  logic [7:0]  cur_month_bcd,
    input  logic [7:0]  cur_day_bcd,
    input  logic [7:0]  rb_hour_bcd,
    input  logic [7:0]  rb_minute_bcd,
    input  logic [7:0]  rb_second_bcd,
    output logic [1:0]  selected_alarm,
    output logic        set,
    output logic [15:0] alarm_year_bcd_in,
    output logic [7:0]  alarm_month_bcd_in,
    output logic [7:0]  alarm_day_bcd_in,
    output logic [7:0]  alarm_hour_bcd_in,
    output logic [7:0]  alarm_minute_bcd_in,
    output logic [7:0]  alarm_second_bcd_in,
    output logic        editing,
    output logic [1:0]  edit_field
);

    localparam int         LAT_W    = $clog2(READBACK_LAT + 1);
    localparam int         TO_W     = $clog2(TIMEOUT_S + 1);
    localparam logic [1:0] SEL_LAST = 2'(NUM_ALARMS - 1);

    state_e      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [15:0] year_q, year_d;
    logic [7:0]  month_q, month_d, day_q, day_d;
    logic [7:0]  hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic        set_q, set_d;
    logic        editing_q, editing_d;
    logic [1:0]  field_q, field_d;

    logic [7:0]  hour_step, min_step, sec_step;
    logic        any_btn;
    logic        timeout_hit;

    // inc outranks dec, so driving the direction from btn_inc alone is enough.
    bcd2_updown #(.MAX(HOUR_MAX))   u_hour (.val_i(hour_q), .up_i(btn_inc), .res_o(hour_step));
    bcd2_updown #(.MAX(MINSEC_MAX)) u_min  (.val_i(min_q),  .up_i(btn_inc), .res_o(min_step));
    bcd2_updown #(.MAX(MINSEC_MAX)) u_sec  (.val_i(sec_q),  .up_i(btn_inc), .res_o(sec_step));

    assign any_btn = btn_mode | btn_next | btn_inc | btn_dec;

    // A button in the same cycle as the terminal tick keeps the session alive.
    assign timeout_hit = (state_q != ST_IDLE) && !any_btn && tick_1hz &&
                         (to_q == TO_W'(TIMEOUT_S - 1));

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        lat_d   = '0;
        year_d  = year_q;
        month_d = month_q;
        day_d   = day_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;

        // Idle time only accumulates inside a session; any press restarts it.
        if (state_q == ST_IDLE || any_btn)
            to_d = '0;
        else if (tick_1hz && !timeout_hit)
            to_d = to_q + TO_W'(1);
        else
            to_d = timeout_hit ? '0 : to_q;

        if (timeout_hit) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (btn_mode) state_d = ST_SELECT;
                end
                ST_SELECT: begin
                    if (btn_mode)
                        state_d = ST_IDLE;
                    else if (btn_next)
                        state_d = ST_LOAD;
                    else if (btn_inc)
                        sel_d = (sel_q == SEL_LAST) ? 2'd0 : sel_q + 2'd1;
                    else if (btn_dec)
                        sel_d = (sel_q == 2'd0) ? SEL_LAST : sel_q - 2'd1;
                end
                ST_LOAD: begin
                    // lat_q counts the cycles spent here; readback is trusted on the last.
                    if (btn_mode) begin
                        state_d = ST_IDLE;
                    end else if (lat_q == LAT_W'(READBACK_LAT - 1)) begin
                        state_d = ST_EDIT_H;
                        hour_d  = rb_hour_bcd;
                        min_d   = rb_minute_bcd;
                        sec_d   = rb_second_bcd;
                        year_d  = cur_year_bcd;
                        month_d = cur_month_bcd;
                        day_d   = cur_day_bcd;
                    end else begin
                        lat_d = lat_q + LAT_W'(1);
                    end
                end
                ST_EDIT_H: begin
                    if (btn_mode)                state_d = ST_IDLE;
                    else if (btn_next)           state_d = ST_EDIT_M;
                    else if (btn_inc || btn_dec) hour_d  = hour_step;
                end
                ST_EDIT_M: begin
                    if (btn_mode)                state_d = ST_IDLE;
                    else if (btn_next)           state_d = ST_EDIT_S;
                    else if (btn_inc || btn_dec) min_d   = min_step;
                end
                ST_EDIT_S: begin
                    if (btn_mode)                state_d = ST_IDLE;
                    else if (btn_next)           state_d = ST_COMMIT;
                    else if (btn_inc || btn_dec) sec_d   = sec_step;
                end
                ST_COMMIT: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Status outputs are derived from the next state so that they are
        // registered yet line up with the state register cycle for cycle.
        set_d     = (state_d == ST_COMMIT);
        editing_d = (state_d != ST_IDLE);
        field_d   = field_of(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= 2'd0;
            lat_q     <= '0;
            to_q      <= '0;
            year_q    <= 16'h0000;
            month_q   <= 8'h00;
            day_q     <= 8'h00;
            hour_q    <= 8'h00;
            min_q     <= 8'h00;
            sec_q     <= 8'h00;
            set_q     <= 1'b0;
            editing_q <= 1'b0;
            field_q   <= FIELD_NONE;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            lat_q     <= lat_d;
            to_q      <= to_d;
            year_q    <= year_d;
            month_q   <= month_d;
            day_q     <= day_d;
            hour_q    <= hour_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            set_q     <= set_d;
            editing_q <= editing_d;
            field_q   <= field_d;
        end
    end

    assign selected_alarm      = sel_q;
    assign set                 = set_q;
    assign alarm_year_bcd_in   = year_q;
    assign alarm_month_bcd_in  = month_q;
    assign alarm_day_bcd_in    = day_q;
    assign alarm_hour_bcd_in   = hour_q;
    assign alarm_minute_bcd_in = min_q;
    assign alarm_second_bcd_in = sec_q;
    assign editing             = editing_q;
    assign edit_field          = field_q;

endmodule

// File: tb/tb_alarm_set_ctrl.sv
module tb_alarm_set_ctrl;

    localparam int NA  = 3;
    localparam int LAT = 4;
    localparam int TO  = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        tick_1hz = 1'b0;
    logic        btn_mode = 1'b0, btn_next = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
    logic [15:0] cur_year_bcd = 16'h2024;
    logic [7:0]  cur_month_bcd = 8'h06, cur_day_bcd = 8'h15;
    logic [7:0]  rb_hour_bcd, rb_minute_bcd, rb_second_bcd;
    logic [1:0]  selected_alarm;
    logic        set;
    logic [15:0] alarm_year_bcd_in;
    logic [7:0]  alarm_month_bcd_in, alarm_day_bcd_in;
    logic [7:0]  alarm_hour_bcd_in, alarm_minute_bcd_in, alarm_second_bcd_in;
    logic        editing;
    logic [1:0]  edit_field;

    int rb_h = 12, rb_m = 34, rb_s = 56;

    alarm_set_ctrl #(.NUM_ALARMS(NA), .READBACK_LAT(LAT), .TIMEOUT_S(TO)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .cur_year_bcd(cur_year_bcd), .cur_month_bcd(cur_month_bcd), .cur_day_bcd(cur_day_bcd),
        .rb_hour_bcd(rb_hour_bcd), .rb_minute_bcd(rb_minute_bcd), .rb_second_bcd(rb_second_bcd),
        .selected_alarm(selected_alarm), .set(set),
        .alarm_year_bcd_in(alarm_year_bcd_in), .alarm_month_bcd_in(alarm_month_bcd_in),
        .alarm_day_bcd_in(alarm_day_bcd_in), .alarm_hour_bcd_in(alarm_hour_bcd_in),
        .alarm_minute_bcd_in(alarm_minute_bcd_in), .alarm_second_bcd_in(alarm_second_bcd_in),
        .editing(editing), .edit_field(edit_field)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    assign rb_hour_bcd   = bcd(rb_h);
    assign rb_minute_bcd = bcd(rb_m);
    assign rb_second_bcd = bcd(rb_s);

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 select, 2 loading, 3..5 editing
    // hour/minute/second, 6 committing. Fields kept as plain integers.
    int ph, sel, wt, idle_s;
    int fld[3];
    int lim[3] = '{24, 60, 60};
    logic [15:0] m_y;
    logic [7:0]  m_mo, m_d;

    task automatic model_reset();
        ph = 0; sel = 0; wt = 0; idle_s = 0;
        fld[0] = 0; fld[1] = 0; fld[2] = 0;
        m_y = 16'h0; m_mo = 8'h0; m_d = 8'h0;
    endtask

    task automatic model_step(input bit m, input bit n, input bit i, input bit d, input bit t);
        bit any;
        any = m | n | i | d;
        if (ph != 0 && !any && t && idle_s == TO - 1) begin
            ph = 0; idle_s = 0;
            return;
        end
        if (ph == 0 || any) idle_s = 0;
        else if (t)         idle_s++;
        case (ph)
            0: if (m) ph = 1;
            1: begin
                if (m)      ph = 0;
                else if (n) begin ph = 2; wt = LAT; end
                else if (i) sel = (sel + 1) % NA;
                else if (d) sel = (sel + NA - 1) % NA;
            end
            2: begin
                if (m) ph = 0;
                else begin
                    wt--;
                    if (wt == 0) begin
                        fld[0] = rb_h; fld[1] = rb_m; fld[2] = rb_s;
                        m_y = cur_year_bcd; m_mo = cur_month_bcd; m_d = cur_day_bcd;
                        ph = 3;
                    end
                end
            end
            3, 4, 5: begin
                if (m)      ph = 0;
                else if (n) ph = ph + 1;
                else if (i) fld[ph-3] = (fld[ph-3] + 1) % lim[ph-3];
                else if (d) fld[ph-3] = (fld[ph-3] + lim[ph-3] - 1) % lim[ph-3];
            end
            default: ph = 0;
        endcase
    endtask

    task automatic check_all();
        chk("sel",     16'(selected_alarm), 16'(sel));
        chk("set",     16'(set), 16'(ph == 6));
        chk("editing", 16'(editing), 16'(ph != 0));
        chk("field",   16'(edit_field), 16'((ph >= 3 && ph <= 5) ? ph - 2 : 0));
        chk("hour",    16'(alarm_hour_bcd_in), 16'(bcd(fld[0])));
        chk("minute",  16'(alarm_minute_bcd_in), 16'(bcd(fld[1])));
        chk("second",  16'(alarm_second_bcd_in), 16'(bcd(fld[2])));
        chk("year",    alarm_year_bcd_in, m_y);
        chk("month",   16'(alarm_month_bcd_in), 16'(m_mo));
        chk("day",     16'(alarm_day_bcd_in), 16'(m_d));
    endtask

    task automatic cyc(input bit m = 0, input bit n = 0, input bit i = 0,
                       input bit d = 0, input bit t = 0);
        btn_mode = m; btn_next = n; btn_inc = i; btn_dec = d; tick_1hz = t;
        @(posedge clk);
        #1;
        model_step(m, n, i, d, t);
        btn_mode = 0; btn_next = 0; btn_inc = 0; btn_dec = 0; tick_1hz = 0;
        check_all();
    endtask

    // mode, next, readback wait: leaves the session in hour edit
    task automatic enter_edit();
        cyc(.m(1));
        cyc(.n(1));
        repeat (LAT) cyc();
    endtask

    logic [7:0] saved;

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_all();
        chk("rst_editing", 16'(editing), 16'h0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;

        // T1: plain session on slot 0
        rb_h = 12; rb_m = 34; rb_s = 56;
        enter_edit();
        chk("t1_field_h", 16'(edit_field), 16'd1);
        repeat (3) cyc(.n(1));
        chk("t1_set", 16'(set), 16'h1);
        chk("t1_hms", {alarm_hour_bcd_in, alarm_minute_bcd_in}, 16'h1234);
        chk("t1_sec", 16'(alarm_second_bcd_in), 16'h0056);
        chk("t1_year", alarm_year_bcd_in, 16'h2024);
        cyc();
        chk("t1_set_low", 16'(set), 16'h0);

        // T2: slot selection wrap
        cyc(.m(1));
        cyc(.d(1));
        chk("t2_dec_wrap", 16'(selected_alarm), 16'd2);
        cyc(.i(1));
        cyc(.i(1));
        chk("t2_inc_wrap", 16'(selected_alarm), 16'd1);
        cyc(.n(1));
        repeat (LAT) cyc();
        repeat (3) cyc(.n(1));
        chk("t2_set", 16'(set), 16'h1);
        chk("t2_sel", 16'(selected_alarm), 16'd1);
        cyc();

        // T3: field wrap and carry
        rb_h = 23; rb_m = 0; rb_s = 59;
        enter_edit();
        cyc(.i(1));
        chk("t3_h_wrap", 16'(alarm_hour_bcd_in), 16'h00);
        cyc(.n(1));
        cyc(.d(1));
        chk("t3_m_wrap", 16'(alarm_minute_bcd_in), 16'h59);
        cyc(.n(1));
        cyc(.i(1));
        chk("t3_s_wrap", 16'(alarm_second_bcd_in), 16'h00);
        repeat (9) cyc(.i(1));
        chk("t3_s_09", 16'(alarm_second_bcd_in), 16'h09);
        cyc(.i(1));
        chk("t3_s_carry", 16'(alarm_second_bcd_in), 16'h10);
        cyc(.m(1));

        // T4: abort from minute edit
        enter_edit();
        cyc(.n(1));
        cyc(.m(1));
        chk("t4_editing", 16'(editing), 16'h0);
        chk("t4_set", 16'(set), 16'h0);
        chk("t4_sel_kept", 16'(selected_alarm), 16'd1);

        // T5: timeout, and a press at tick 9 restarting the count
        enter_edit();
        repeat (2) cyc(.n(1));
        repeat (8) cyc(.t(1));
        cyc(.i(1), .t(1));
        repeat (9) cyc(.t(1));
        chk("t5_restart", 16'(editing), 16'h1);
        cyc(.t(1));
        chk("t5_timeout", 16'(editing), 16'h0);
        chk("t5_no_set", 16'(set), 16'h0);

        // T6: priority next over inc, then reset mid-edit
        rb_h = 7; rb_m = 8; rb_s = 9;
        enter_edit();
        saved = alarm_hour_bcd_in;
        cyc(.n(1), .i(1));
        chk("t6_field_m", 16'(edit_field), 16'd2);
        chk("t6_hour_same", 16'(alarm_hour_bcd_in), 16'(saved));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk) rst_n = 1'b1;

        // Randomized traffic
        for (int k = 0; k < 4000; k++) begin
            bit m, n, i, d, t;
            bit quiet;
            quiet = ((k / 200) % 4) == 3;
            if ($urandom_range(0, 19) == 0) begin
                rb_h = $urandom_range(0, 23);
                rb_m = $urandom_range(0, 59);
                rb_s = $urandom_range(0, 59);
                cur_year_bcd  = 16'($urandom);
                cur_month_bcd = 8'($urandom);
                cur_day_bcd   = 8'($urandom);
            end
            m = ($urandom_range(0, 99) < (quiet ? 1 : 4));
            n = ($urandom_range(0, 99) < (quiet ? 1 : 12));
            i = ($urandom_range(0, 99) < (quiet ? 1 : 15));
            d = ($urandom_range(0, 99) < (quiet ? 1 : 12));
            t = ($urandom_range(0, 99) < 35);
            cyc(m, n, i, d, t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
